// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, threshold flags
// and sticky overflow/underflow error flags.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wp;
  logic [ADDR_WIDTH-1:0] rp;
  logic                  rd_ok;
  logic                  wr_ok;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a write.
  always_comb begin
    rd_ok = rd && !empty;
    wr_ok = wr && (!full || rd_ok);
  end

  // Status flags follow the registered count directly.
  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == CW'(0));
    almost_full  = (count >= CW'(AF_LEVEL));
    almost_empty = (count <= CW'(AE_LEVEL));
  end

  // Storage array; intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      r_valid <= rd_ok;
      if (wr_ok) begin
        wp <= wp + ADDR_WIDTH'(1);
      end
      if (rd_ok) begin
        r_data <= mem[rp];
        rp     <= rp + ADDR_WIDTH'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (rd && !rd_ok) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo at default parameters (8 x 8-bit).
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       r_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .r_valid      (r_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request set, clock it in, and settle 1 ns after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr     = w;
    w_data = d;
    rd     = r;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_aempty"}, 32'(almost_empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_afull"}, 32'(almost_full), 32'd0);
    chk({tag, "_rdata"}, 32'(r_data), 32'd0);
    chk({tag, "_rvalid"}, 32'(r_valid), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    reset  = 1'b1;
    wr     = 1'b0;
    rd     = 1'b0;
    w_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    reset = 1'b0;

    // Fill 8 words 0F,1E,...,78 and track flags.
    for (int i = 1; i <= 8; i++) begin
      v = 8'(15 * i);
      cyc(1'b1, v, 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full), (i == 8) ? 32'd1 : 32'd0);
      chk("fill_aempty", 32'(almost_empty), (i <= 2) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain_rvalid", 32'(r_valid), 32'd1);
      chk("drain_rdata", 32'(r_data), 32'(8'(15 * i)));
      chk("drain_count", 32'(count), 32'(8 - i));
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_rvalid", 32'(r_valid), 32'd0);
    chk("idle_rdata_hold", 32'(r_data), 32'h78);
    chk("drain_empty", 32'(empty), 32'd1);

    // Overflow: write to full FIFO is refused.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(15 * i), 1'b0);
    chk("ovf_pre", 32'(overflow), 32'd0);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("ovf_rdata", 32'(r_data), 32'(8'(15 * i)));
    end
    chk("ovf_empty", 32'(empty), 32'd1);

    // Underflow, then simultaneous wr/rd on empty.
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_rvalid", 32'(r_valid), 32'd0);
    chk("unf_rdata", 32'(r_data), 32'h78);
    cyc(1'b1, 8'h32, 1'b1);
    chk("wrrd_empty_count", 32'(count), 32'd1);
    chk("wrrd_empty_rvalid", 32'(r_valid), 32'd0);
    chk("wrrd_empty_rdata", 32'(r_data), 32'h78);
    cyc(1'b0, 8'h00, 1'b1);
    chk("wrrd_empty_read", 32'(r_data), 32'h32);
    chk("wrrd_empty_rv", 32'(r_valid), 32'd1);

    // Full FIFO with wr=rd=1 for three cycles.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 8'(15 * i), 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 8'h55, 1'b1);
      chk("fullrw_count", 32'(count), 32'd8);
      chk("fullrw_rdata", 32'(r_data), 32'(8'(15 * i)));
      chk("fullrw_rvalid", 32'(r_valid), 32'd1);
    end
    chk("fullrw_ovf_sticky", 32'(overflow), 32'd1);
    for (int i = 4; i <= 11; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("fullrw_drain", 32'(r_data), (i <= 8) ? 32'(8'(15 * i)) : 32'h55);
    end

    // Streaming with one word prefilled: pointers wrap repeatedly.
    cyc(1'b1, 8'h80, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(8'h81 + i), 1'b1);
      chk("stream_rdata", 32'(r_data), 32'(8'(8'h80 + i)));
      chk("stream_count", 32'(count), 32'd1);
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("stream_last", 32'(r_data), 32'h94);
    chk("stream_empty", 32'(empty), 32'd1);

    // Asynchronous reset mid-burst with five words stored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
    wr     = 1'b1;
    w_data = 8'hA5;
    rd     = 1'b1;
    @(posedge clk);
    #1;
    chk("burst_count", 32'(count), 32'd5);
    chk("burst_rvalid", 32'(r_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_state("arst");
    #2;
    reset = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 8'h3C, 1'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post_rst_rdata", 32'(r_data), 32'h3C);
    chk("post_rst_rvalid", 32'(r_valid), 32'd1);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
